// File: rtl/order_matcher.sv
`default_nettype none
// order_matcher: price-time-priority matcher. Each sample strobe submits one bid and one ask,
// which are matched against a sorted DEPTH-entry resting book per side. Rev 1.0
module order_matcher #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        sample_en,
   input  logic [7:0]  buy_price,
   input  logic [7:0]  sell_price,
   output logic        busy,
   output logic        trade_valid,
   output logic [7:0]  trade_price,
   output logic        trade_side,
   output logic [15:0] trade_count,
   output logic [7:0]  drop_count,
   output logic [7:0]  overrun_count,
   output logic [7:0]  best_bid,
   output logic [7:0]  best_ask,
   output logic [3:0]  bid_count,
   output logic [3:0]  ask_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BID  = 2'd1,
      ASK  = 2'd2
   } state_t;

   localparam logic [3:0] C_DEPTH = 4'(DEPTH);

   state_t      state_q;
   logic [7:0]  in_bid_q, in_ask_q;
   logic [7:0]  bids_q [DEPTH];
   logic [7:0]  asks_q [DEPTH];
   logic [3:0]  bid_cnt_q, ask_cnt_q;
   logic        busy_q, trade_valid_q, trade_side_q;
   logic [7:0]  trade_price_q, drop_q, overrun_q;
   logic [15:0] trade_cnt_q;

   logic [7:0]  bid_ins [DEPTH];
   logic [7:0]  ask_ins [DEPTH];
   logic [7:0]  bid_shr [DEPTH];
   logic [7:0]  ask_shr [DEPTH];
   logic [7:0]  bid_pop [DEPTH];
   logic [7:0]  ask_pop [DEPTH];
   logic [3:0]  bid_pos, ask_pos;
   logic        bid_cross, ask_cross, bid_full, ask_full, bid_beats, ask_beats;

   // Empty slots hold 8'h00 (bids) / 8'hFF (asks) so slot 0 is directly the best-price output.
   always_comb begin
      bid_pos = 4'd0;
      ask_pos = 4'd0;
      for (int i = 0; i < DEPTH; i++) begin
         if ((4'(i) < bid_cnt_q) && (bids_q[i] >= in_bid_q)) bid_pos = bid_pos + 4'd1;
         if ((4'(i) < ask_cnt_q) && (asks_q[i] <= in_ask_q)) ask_pos = ask_pos + 4'd1;
      end
      bid_shr[0]       = in_bid_q;
      ask_shr[0]       = in_ask_q;
      bid_pop[DEPTH-1] = 8'h00;
      ask_pop[DEPTH-1] = 8'hFF;
      for (int i = 1; i < DEPTH; i++) begin
         bid_shr[i]   = bids_q[i-1];
         ask_shr[i]   = asks_q[i-1];
         bid_pop[i-1] = bids_q[i];
         ask_pop[i-1] = asks_q[i];
      end
      // Insert behind existing equal prices; on a full book the tail falls off.
      for (int i = 0; i < DEPTH; i++) begin
         if (4'(i) < bid_pos)       bid_ins[i] = bids_q[i];
         else if (4'(i) == bid_pos) bid_ins[i] = in_bid_q;
         else                       bid_ins[i] = bid_shr[i];
         if (4'(i) < ask_pos)       ask_ins[i] = asks_q[i];
         else if (4'(i) == ask_pos) ask_ins[i] = in_ask_q;
         else                       ask_ins[i] = ask_shr[i];
      end
   end

   assign bid_cross = (ask_cnt_q != 4'd0) && (in_bid_q >= asks_q[0]);
   assign ask_cross = (bid_cnt_q != 4'd0) && (bids_q[0] >= in_ask_q);
   assign bid_full  = (bid_cnt_q == C_DEPTH);
   assign ask_full  = (ask_cnt_q == C_DEPTH);
   assign bid_beats = (in_bid_q > bids_q[DEPTH-1]);
   assign ask_beats = (in_ask_q < asks_q[DEPTH-1]);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         in_bid_q      <= 8'h00;
         in_ask_q      <= 8'h00;
         bid_cnt_q     <= 4'd0;
         ask_cnt_q     <= 4'd0;
         busy_q        <= 1'b0;
         trade_valid_q <= 1'b0;
         trade_side_q  <= 1'b0;
         trade_price_q <= 8'h00;
         trade_cnt_q   <= 16'h0000;
         drop_q        <= 8'h00;
         overrun_q     <= 8'h00;
         for (int i = 0; i < DEPTH; i++) begin
            bids_q[i] <= 8'h00;
            asks_q[i] <= 8'hFF;
         end
      end else if (clear) begin
         state_q       <= IDLE;
         bid_cnt_q     <= 4'd0;
         ask_cnt_q     <= 4'd0;
         busy_q        <= 1'b0;
         trade_valid_q <= 1'b0;
         trade_price_q <= 8'h00;
         trade_cnt_q   <= 16'h0000;
         drop_q        <= 8'h00;
         overrun_q     <= 8'h00;
         for (int i = 0; i < DEPTH; i++) begin
            bids_q[i] <= 8'h00;
            asks_q[i] <= 8'hFF;
         end
      end else begin
         trade_valid_q <= 1'b0;
         if (sample_en && (state_q != IDLE) && (overrun_q != 8'hFF))
            overrun_q <= overrun_q + 8'd1;
         case (state_q)
            IDLE: begin
               if (sample_en) begin
                  in_bid_q <= buy_price;
                  in_ask_q <= sell_price;
                  busy_q   <= 1'b1;
                  state_q  <= BID;
               end
            end
            BID: begin
               if (bid_cross) begin
                  trade_valid_q <= 1'b1;
                  trade_price_q <= asks_q[0];
                  trade_side_q  <= 1'b1;
                  trade_cnt_q   <= trade_cnt_q + 16'd1;
                  asks_q        <= ask_pop;
                  ask_cnt_q     <= ask_cnt_q - 4'd1;
               end else if (!bid_full) begin
                  bids_q    <= bid_ins;
                  bid_cnt_q <= bid_cnt_q + 4'd1;
               end else begin
                  if (bid_beats) bids_q <= bid_ins;
                  if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
               end
               state_q <= ASK;
            end
            ASK: begin
               if (ask_cross) begin
                  trade_valid_q <= 1'b1;
                  trade_price_q <= bids_q[0];
                  trade_side_q  <= 1'b0;
                  trade_cnt_q   <= trade_cnt_q + 16'd1;
                  bids_q        <= bid_pop;
                  bid_cnt_q     <= bid_cnt_q - 4'd1;
               end else if (!ask_full) begin
                  asks_q    <= ask_ins;
                  ask_cnt_q <= ask_cnt_q + 4'd1;
               end else begin
                  if (ask_beats) asks_q <= ask_ins;
                  if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
               end
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy          = busy_q;
   assign trade_valid   = trade_valid_q;
   assign trade_price   = trade_price_q;
   assign trade_side    = trade_side_q;
   assign trade_count   = trade_cnt_q;
   assign drop_count    = drop_q;
   assign overrun_count = overrun_q;
   assign best_bid      = bids_q[0];
   assign best_ask      = asks_q[0];
   assign bid_count     = bid_cnt_q;
   assign ask_count     = ask_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_order_matcher.sv
`default_nettype none
// tb_order_matcher: directed vector table plus hand-written overrun/clear/reset sequences. Rev 1.0
module tb_order_matcher;

   logic        clk = 1'b0;
   logic        reset, clear, sample_en;
   logic [7:0]  buy_price, sell_price;
   logic        busy, trade_valid, trade_side;
   logic [7:0]  trade_price, drop_count, overrun_count, best_bid, best_ask;
   logic [15:0] trade_count;
   logic [3:0]  bid_count, ask_count;

   int n_pass  = 0;
   int n_total = 0;

   order_matcher #(.DEPTH(4)) dut (
      .clk(clk), .reset(reset), .clear(clear), .sample_en(sample_en),
      .buy_price(buy_price), .sell_price(sell_price),
      .busy(busy), .trade_valid(trade_valid), .trade_price(trade_price),
      .trade_side(trade_side), .trade_count(trade_count), .drop_count(drop_count),
      .overrun_count(overrun_count), .best_bid(best_bid), .best_ask(best_ask),
      .bid_count(bid_count), .ask_count(ask_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0]  buy;
      logic [7:0]  sell;
      logic        b_tv;
      logic [7:0]  b_px;
      logic        a_tv;
      logic [7:0]  a_px;
      logic [7:0]  bb;
      logic [7:0]  ba;
      logic [3:0]  bc;
      logic [3:0]  ac;
      logic [15:0] tc;
      logic [7:0]  dc;
      logic [7:0]  lp;
   } vec_t;

   vec_t vecs [16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      @(posedge clk); #1;
      sample_en = 1'b1; buy_price = v.buy; sell_price = v.sell;
      @(posedge clk); #1;
      sample_en = 1'b0;
      chk($sformatf("v%0d busy", idx), 32'(busy), 32'd1);
      @(posedge clk); #1;
      chk($sformatf("v%0d bid_tv", idx), 32'(trade_valid), 32'(v.b_tv));
      if (v.b_tv) begin
         chk($sformatf("v%0d bid_px", idx), 32'(trade_price), 32'(v.b_px));
         chk($sformatf("v%0d bid_side", idx), 32'(trade_side), 32'd1);
      end
      @(posedge clk); #1;
      chk($sformatf("v%0d ask_tv", idx), 32'(trade_valid), 32'(v.a_tv));
      if (v.a_tv) begin
         chk($sformatf("v%0d ask_px", idx), 32'(trade_price), 32'(v.a_px));
         chk($sformatf("v%0d ask_side", idx), 32'(trade_side), 32'd0);
      end
      chk($sformatf("v%0d busy_end", idx), 32'(busy), 32'd0);
      chk($sformatf("v%0d best_bid", idx), 32'(best_bid), 32'(v.bb));
      chk($sformatf("v%0d best_ask", idx), 32'(best_ask), 32'(v.ba));
      chk($sformatf("v%0d bid_cnt", idx), 32'(bid_count), 32'(v.bc));
      chk($sformatf("v%0d ask_cnt", idx), 32'(ask_count), 32'(v.ac));
      chk($sformatf("v%0d trade_cnt", idx), 32'(trade_count), 32'(v.tc));
      chk($sformatf("v%0d drop_cnt", idx), 32'(drop_count), 32'(v.dc));
      chk($sformatf("v%0d last_px", idx), 32'(trade_price), 32'(v.lp));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      //               buy    sell   btv  bpx    atv  apx    bb     ba     bc    ac    tc      dc    lp
      vecs[0]  = '{8'd60, 8'd70, 1'b0, 8'd0,  1'b0, 8'd0,  8'd60, 8'd70, 4'd1, 4'd1, 16'd0, 8'd0, 8'd0};
      vecs[1]  = '{8'd72, 8'd80, 1'b1, 8'd70, 1'b0, 8'd0,  8'd60, 8'd80, 4'd1, 4'd1, 16'd1, 8'd0, 8'd70};
      vecs[2]  = '{8'd50, 8'd66, 1'b0, 8'd0,  1'b0, 8'd0,  8'd60, 8'd66, 4'd2, 4'd2, 16'd1, 8'd0, 8'd70};
      vecs[3]  = '{8'd66, 8'd90, 1'b1, 8'd66, 1'b0, 8'd0,  8'd60, 8'd80, 4'd2, 4'd2, 16'd2, 8'd0, 8'd66};
      vecs[4]  = '{8'd40, 8'd55, 1'b0, 8'd0,  1'b1, 8'd60, 8'd50, 8'd80, 4'd2, 4'd2, 16'd3, 8'd0, 8'd60};
      vecs[5]  = '{8'd85, 8'd45, 1'b1, 8'd80, 1'b1, 8'd50, 8'd40, 8'd90, 4'd1, 4'd1, 16'd5, 8'd0, 8'd50};
      vecs[6]  = '{8'd70, 8'd65, 1'b0, 8'd0,  1'b1, 8'd70, 8'h00, 8'hFF, 4'd0, 4'd0, 16'd1, 8'd0, 8'd70};
      vecs[7]  = '{8'd52, 8'd90, 1'b0, 8'd0,  1'b0, 8'd0,  8'd52, 8'd90, 4'd1, 4'd1, 16'd1, 8'd0, 8'd70};
      vecs[8]  = '{8'd55, 8'd91, 1'b0, 8'd0,  1'b0, 8'd0,  8'd55, 8'd90, 4'd2, 4'd2, 16'd1, 8'd0, 8'd70};
      vecs[9]  = '{8'd58, 8'd92, 1'b0, 8'd0,  1'b0, 8'd0,  8'd58, 8'd90, 4'd3, 4'd3, 16'd1, 8'd0, 8'd70};
      vecs[10] = '{8'd60, 8'd93, 1'b0, 8'd0,  1'b0, 8'd0,  8'd60, 8'd90, 4'd4, 4'd4, 16'd1, 8'd0, 8'd70};
      vecs[11] = '{8'd53, 8'd94, 1'b0, 8'd0,  1'b0, 8'd0,  8'd60, 8'd90, 4'd4, 4'd4, 16'd1, 8'd2, 8'd70};
      vecs[12] = '{8'd50, 8'd89, 1'b0, 8'd0,  1'b0, 8'd0,  8'd60, 8'd89, 4'd4, 4'd4, 16'd1, 8'd4, 8'd70};
      vecs[13] = '{8'd0,  8'd0,  1'b0, 8'd0,  1'b1, 8'd60, 8'd58, 8'd89, 4'd3, 4'd4, 16'd2, 8'd5, 8'd60};
      vecs[14] = '{8'd0,  8'd0,  1'b0, 8'd0,  1'b1, 8'd58, 8'd55, 8'd89, 4'd3, 4'd4, 16'd3, 8'd5, 8'd58};
      vecs[15] = '{8'd0,  8'd0,  1'b0, 8'd0,  1'b1, 8'd55, 8'd53, 8'd89, 4'd3, 4'd4, 16'd4, 8'd5, 8'd55};

      reset = 1'b1; clear = 1'b0; sample_en = 1'b0; buy_price = 8'd0; sell_price = 8'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst tv", 32'(trade_valid), 32'd0);
      chk("rst px", 32'(trade_price), 32'd0);
      chk("rst side", 32'(trade_side), 32'd0);
      chk("rst tc", 32'(trade_count), 32'd0);
      chk("rst dc", 32'(drop_count), 32'd0);
      chk("rst oc", 32'(overrun_count), 32'd0);
      chk("rst bb", 32'(best_bid), 32'h00);
      chk("rst ba", 32'(best_ask), 32'hFF);
      chk("rst bc", 32'(bid_count), 32'd0);
      chk("rst ac", 32'(ask_count), 32'd0);
      reset = 1'b0;

      for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

      // Overrun: sample_en held two cycles; the second lands in BID.
      @(posedge clk); #1;
      sample_en = 1'b1; buy_price = 8'd100; sell_price = 8'd10;
      @(posedge clk); #1;
      @(posedge clk); #1;
      sample_en = 1'b0;
      chk("ovr bid_tv", 32'(trade_valid), 32'd1);
      chk("ovr bid_px", 32'(trade_price), 32'd90);
      @(posedge clk); #1;
      chk("ovr ask_tv", 32'(trade_valid), 32'd1);
      chk("ovr ask_px", 32'(trade_price), 32'd40);
      chk("ovr count", 32'(overrun_count), 32'd1);
      chk("ovr tc", 32'(trade_count), 32'd7);
      @(posedge clk); #1;
      chk("ovr idle", 32'(busy), 32'd0);

      // Build a crossing book, then clear while the sample sits in BID.
      run_vec(100, '{8'd30, 8'd200, 1'b0, 8'd0, 1'b0, 8'd0, 8'd30, 8'd200, 4'd1, 4'd1, 16'd7, 8'd0, 8'd40});
      @(posedge clk); #1;
      sample_en = 1'b1; buy_price = 8'd250; sell_price = 8'd5;
      @(posedge clk); #1;
      sample_en = 1'b0; clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      chk("clr busy", 32'(busy), 32'd0);
      chk("clr tv", 32'(trade_valid), 32'd0);
      chk("clr bb", 32'(best_bid), 32'h00);
      chk("clr ba", 32'(best_ask), 32'hFF);
      chk("clr bc", 32'(bid_count), 32'd0);
      chk("clr ac", 32'(ask_count), 32'd0);
      chk("clr tc", 32'(trade_count), 32'd0);
      chk("clr oc", 32'(overrun_count), 32'd0);
      chk("clr px", 32'(trade_price), 32'd0);
      @(posedge clk); #1;
      chk("clr tv2", 32'(trade_valid), 32'd0);
      chk("clr bc2", 32'(bid_count), 32'd0);

      for (int i = 6; i < 16; i++) run_vec(i, vecs[i]);

      // Asynchronous reset while a crossing sample is in BID.
      @(posedge clk); #1;
      sample_en = 1'b1; buy_price = 8'd255; sell_price = 8'd0;
      @(posedge clk); #1;
      sample_en = 1'b0;
      chk("arst pre busy", 32'(busy), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("arst busy", 32'(busy), 32'd0);
      chk("arst tv", 32'(trade_valid), 32'd0);
      chk("arst bb", 32'(best_bid), 32'h00);
      chk("arst ba", 32'(best_ask), 32'hFF);
      chk("arst bc", 32'(bid_count), 32'd0);
      chk("arst ac", 32'(ask_count), 32'd0);
      chk("arst tc", 32'(trade_count), 32'd0);
      chk("arst dc", 32'(drop_count), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      chk("arst tv2", 32'(trade_valid), 32'd0);
      chk("arst busy2", 32'(busy), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
